// File: rtl/norm_shift_pkg.sv
// Shared constants for the left normalizer: data/count widths and FSM state encoding.
package norm_shift_pkg;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 6;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/norm_step.sv
// One normalization step: picks the shift amount k for the current operand and applies it.
// NORM_SHIFT_FAST_EN selects coarse 16/4/1 stepping; otherwise every step shifts by one.
module norm_step
  import norm_shift_pkg::*;
(
  input  logic [DATA_W-1:0] res_in,
  output logic [DATA_W-1:0] res_out,
  output logic [CNT_W-1:0]  step_k
);

  // Coarse steps never overshoot: a 16 or 4 shift is only taken when that many top bits are zero.
  always_comb begin
    step_k = CNT_W'(1);
`ifdef NORM_SHIFT_FAST_EN
    if (res_in[31:16] == 16'h0000) begin
      step_k = CNT_W'(16);
    end else if (res_in[31:28] == 4'h0) begin
      step_k = CNT_W'(4);
    end
`endif
    res_out = res_in << step_k;
  end

endmodule

// File: rtl/norm_shift.sv
// Iterative left normalizer with start/done handshake; busy/done decode from the state register.
// Step rule is set by NORM_SHIFT_FAST_EN inside norm_step.
module norm_shift
  import norm_shift_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] value,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] res,
  output logic [CNT_W-1:0]  shcnt,
  output logic              zero
);

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic [CNT_W-1:0]  shcnt_q, shcnt_d;
  logic              zero_q, zero_d;

  logic [DATA_W-1:0] step_res;
  logic [CNT_W-1:0]  step_k;

  norm_step u_step (
    .res_in  (res_q),
    .res_out (step_res),
    .step_k  (step_k)
  );

  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    shcnt_d = shcnt_q;
    zero_d  = zero_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          res_d   = value;
          shcnt_d = '0;
          zero_d  = (value == '0);
          state_d = (value[31] || value == '0) ? ST_DONE : ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        res_d   = step_res;
        shcnt_d = shcnt_q + step_k;
        if (step_res[31]) begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      res_q   <= '0;
      shcnt_q <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      shcnt_q <= shcnt_d;
      zero_q  <= zero_d;
    end
  end

  assign busy  = (state_q == ST_SHIFT);
  assign done  = (state_q == ST_DONE);
  assign res   = res_q;
  assign shcnt = shcnt_q;
  assign zero  = zero_q;

endmodule
